// File: rtl/lagarto_plic_target_controller.sv
// Lagarto PLIC per-target core: pending latch, iterative best-source scan,
// notification against threshold and the claim/complete handshake.
module lagarto_plic_target_controller #(
  parameter int NUMBER_OF_INTERRUPT_SOURCES = 32,
  parameter int PRIORITY_WIDTH              = 3,
  parameter int MXLEN                       = 64
) (
  input  logic                                                  clk_i,
  input  logic                                                  rstn_i,
  input  logic [NUMBER_OF_INTERRUPT_SOURCES-1:0]                interrupt_request_i,
  input  logic [NUMBER_OF_INTERRUPT_SOURCES*PRIORITY_WIDTH-1:0] interrupt_priority_i,
  input  logic [NUMBER_OF_INTERRUPT_SOURCES-1:0]                interrupt_enable_i,
  input  logic [PRIORITY_WIDTH-1:0]                             interrupt_threshold_i,
  input  logic                                                  interrupt_claim_i,
  input  logic                                                  interrupt_complete_i,
  output logic                                                  interrupt_notification_o,
  output logic [MXLEN-1:0]                                      interrupt_id_o,
  output logic [NUMBER_OF_INTERRUPT_SOURCES-1:0]                interrupt_complete_o,
  output logic [NUMBER_OF_INTERRUPT_SOURCES-1:0]                interrupt_pending_o
);

  localparam int N   = NUMBER_OF_INTERRUPT_SOURCES;
  localparam int PW  = PRIORITY_WIDTH;
  localparam int IDW = $clog2(N);

  localparam logic [IDW-1:0] FIRST_IDX = IDW'(1);
  localparam logic [IDW-1:0] LAST_IDX  = IDW'(N-1);
  localparam logic [N-1:0]   SRC_MASK  = {{(N-1){1'b1}}, 1'b0};

  typedef enum logic {
    READY,
    CLAIMED
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     pending_q, pending_d;
  logic [IDW-1:0]   scan_idx_q, scan_idx_d;
  logic [IDW-1:0]   best_id_q, best_id_d;
  logic [PW-1:0]    best_prio_q, best_prio_d;
  logic [IDW-1:0]   result_id_q, result_id_d;
  logic [PW-1:0]    result_prio_q, result_prio_d;
  logic [IDW-1:0]   claimed_id_q, claimed_id_d;
  logic             notif_q, notif_d;
  logic [MXLEN-1:0] id_q, id_d;
  logic [N-1:0]     complete_q, complete_d;

  logic [PW-1:0]  prio_arr [N];
  logic [IDW-1:0] run_id;
  logic [PW-1:0]  run_prio;
  logic [PW-1:0]  cur_prio;
  logic           cand;
  logic [IDW-1:0] scan_id;
  logic [PW-1:0]  scan_prio;
  logic [IDW-1:0] claim_id;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      prio_arr[k] = interrupt_priority_i[k*PW +: PW];
    end
  end

  // Running best restarts at the first index of every sweep
  always_comb begin
    run_id    = best_id_q;
    run_prio  = best_prio_q;
    if (scan_idx_q == FIRST_IDX) begin
      run_id   = '0;
      run_prio = '0;
    end
    cur_prio  = prio_arr[scan_idx_q];
    cand      = pending_q[scan_idx_q]
              & interrupt_enable_i[scan_idx_q]
              & (cur_prio != '0)
              & (cur_prio > run_prio);
    scan_id   = cand ? scan_idx_q : run_id;
    scan_prio = cand ? cur_prio   : run_prio;
  end

  assign claim_id = notif_q ? result_id_q : '0;

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    best_id_d     = scan_id;
    best_prio_d   = scan_prio;
    result_id_d   = result_id_q;
    result_prio_d = result_prio_q;
    claimed_id_d  = claimed_id_q;
    id_d          = id_q;
    complete_d    = '0;
    scan_idx_d    = scan_idx_q + FIRST_IDX;
    notif_d       = (result_prio_q > interrupt_threshold_i)
                  && (result_id_q != '0)
                  && (state_q == READY);

    if (scan_idx_q == LAST_IDX) begin
      scan_idx_d    = FIRST_IDX;
      result_id_d   = scan_id;
      result_prio_d = scan_prio;
    end

    unique case (state_q)
      READY: begin
        if (interrupt_claim_i) begin
          id_d = MXLEN'(claim_id);
          if (claim_id != '0) begin
            pending_d[claim_id] = 1'b0;
            claimed_id_d        = claim_id;
            notif_d             = 1'b0;
            result_id_d         = '0;
            result_prio_d       = '0;
            best_id_d           = '0;
            best_prio_d         = '0;
            scan_idx_d          = FIRST_IDX;
            state_d             = CLAIMED;
          end
        end
      end
      CLAIMED: begin
        notif_d = 1'b0;
        if (interrupt_claim_i) begin
          id_d = '0;
        end
        if (interrupt_complete_i) begin
          complete_d[claimed_id_q] = 1'b1;
          state_d                  = READY;
        end
      end
      default: state_d = READY;
    endcase

    // A new request wins over a same-cycle claim clear
    pending_d = pending_d | (interrupt_request_i & SRC_MASK);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= READY;
      pending_q     <= '0;
      scan_idx_q    <= FIRST_IDX;
      best_id_q     <= '0;
      best_prio_q   <= '0;
      result_id_q   <= '0;
      result_prio_q <= '0;
      claimed_id_q  <= '0;
      notif_q       <= 1'b0;
      id_q          <= '0;
      complete_q    <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      scan_idx_q    <= scan_idx_d;
      best_id_q     <= best_id_d;
      best_prio_q   <= best_prio_d;
      result_id_q   <= result_id_d;
      result_prio_q <= result_prio_d;
      claimed_id_q  <= claimed_id_d;
      notif_q       <= notif_d;
      id_q          <= id_d;
      complete_q    <= complete_d;
    end
  end

  assign interrupt_notification_o = notif_q;
  assign interrupt_id_o           = id_q;
  assign interrupt_complete_o     = complete_q;
  assign interrupt_pending_o      = pending_q;

endmodule

// File: tb/tb_lagarto_plic_target_controller.sv
// Directed bench for the PLIC target controller with a claim/complete
// scoreboard and bounded waits on notification.
module tb_lagarto_plic_target_controller;

  localparam int N  = 32;
  localparam int PW = 3;
  localparam int XL = 64;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    req;
  logic [N*PW-1:0] prio;
  logic [N-1:0]    en;
  logic [PW-1:0]   thr;
  logic            claim;
  logic            comp;
  logic            notif;
  logic [XL-1:0]   id_o;
  logic [N-1:0]    cpl_o;
  logic [N-1:0]    pend_o;

  int checks = 0;
  int errors = 0;

  logic [XL-1:0] id_sb [$];
  logic [N-1:0]  cp_sb [$];

  lagarto_plic_target_controller #(
    .NUMBER_OF_INTERRUPT_SOURCES(N),
    .PRIORITY_WIDTH(PW),
    .MXLEN(XL)
  ) dut (
    .clk_i(clk),
    .rstn_i(rstn),
    .interrupt_request_i(req),
    .interrupt_priority_i(prio),
    .interrupt_enable_i(en),
    .interrupt_threshold_i(thr),
    .interrupt_claim_i(claim),
    .interrupt_complete_i(comp),
    .interrupt_notification_o(notif),
    .interrupt_id_o(id_o),
    .interrupt_complete_o(cpl_o),
    .interrupt_pending_o(pend_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_prio(input int k, input int p);
    prio[k*PW +: PW] = PW'(p);
  endtask

  task automatic pulse_req(input logic [N-1:0] m);
    req = m;
    tick();
    req = '0;
  endtask

  task automatic do_reset();
    rstn  = 1'b0;
    req   = '0;
    prio  = '0;
    en    = '0;
    thr   = '0;
    claim = 1'b0;
    comp  = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic wait_notif(input string tag);
    int n = 0;
    while (notif !== 1'b1 && n < 62) begin
      tick();
      n++;
    end
    chk(tag, 64'(notif), 64'd1);
  endtask

  task automatic wait_clear(input string tag);
    int n = 0;
    while (notif !== 1'b0 && n < 62) begin
      tick();
      n++;
    end
    chk(tag, 64'(notif), 64'd0);
  endtask

  task automatic watch_quiet(input int cyc, input string tag);
    logic seen = 1'b0;
    repeat (cyc) begin
      tick();
      if (notif !== 1'b0) seen = 1'b1;
    end
    chk(tag, 64'(seen), 64'd0);
  endtask

  task automatic do_claim(input logic [XL-1:0] exp_id);
    id_sb.push_back(exp_id);
    claim = 1'b1;
    tick();
    claim = 1'b0;
    chk("claim_id", id_o, id_sb.pop_front());
  endtask

  task automatic do_complete(input logic [N-1:0] exp_mask);
    cp_sb.push_back(exp_mask);
    comp = 1'b1;
    tick();
    comp = 1'b0;
    chk("cpl_pulse", 64'(cpl_o), 64'(cp_sb.pop_front()));
    tick();
    chk("cpl_end", 64'(cpl_o), 64'd0);
  endtask

  initial begin
    do_reset();
    chk("rst_notif", 64'(notif), 64'd0);
    chk("rst_id", id_o, 64'd0);
    chk("rst_cpl", 64'(cpl_o), 64'd0);
    chk("rst_pend", 64'(pend_o), 64'd0);

    // T1: asynchronous reset mid-scan, then mid-claim
    en = '1;
    pulse_req(32'h6);
    repeat (5) tick();
    chk("t1_pend", 64'(pend_o), 64'h6);
    #2 rstn = 1'b0;
    #1;
    chk("t1_async_pend", 64'(pend_o), 64'd0);
    chk("t1_async_notif", 64'(notif), 64'd0);
    chk("t1_async_id", id_o, 64'd0);
    tick();
    rstn = 1'b1;
    repeat (4) tick();
    chk("t1_post_cpl", 64'(cpl_o), 64'd0);
    chk("t1_post_pend", 64'(pend_o), 64'd0);
    en = '1;
    set_prio(1, 1);
    pulse_req(32'h2);
    wait_notif("t1_notif");
    do_claim(64'd1);
    #2 rstn = 1'b0;
    #1;
    chk("t1_claim_rst_id", id_o, 64'd0);
    tick();
    rstn = 1'b1;
    tick();
    do_complete('0);

    // T2: single source
    do_reset();
    en = '1;
    set_prio(5, 3);
    pulse_req(32'h20);
    chk("t2_pend", 64'(pend_o), 64'h20);
    wait_notif("t2_notif");
    do_claim(64'd5);
    chk("t2_pend_clr", 64'(pend_o), 64'd0);
    chk("t2_notif_clr", 64'(notif), 64'd0);
    do_complete(32'h20);

    // T3: priority and lowest-ID tie break
    do_reset();
    en = '1;
    set_prio(3, 2);
    set_prio(7, 2);
    set_prio(9, 5);
    pulse_req(32'h288);
    wait_notif("t3_notif_a");
    do_claim(64'd9);
    do_complete(32'h200);
    wait_notif("t3_notif_b");
    do_claim(64'd3);
    do_complete(32'h8);
    wait_notif("t3_notif_c");
    do_claim(64'd7);
    do_complete(32'h80);

    // T4: threshold and enable
    do_reset();
    en  = '1;
    thr = 3'd2;
    set_prio(4, 2);
    pulse_req(32'h10);
    watch_quiet(70, "t4_thr_block");
    thr = 3'd1;
    wait_notif("t4_thr_pass");
    en[4] = 1'b0;
    wait_clear("t4_en_clear");
    chk("t4_pend_kept", 64'(pend_o), 64'h10);

    // T5: handshake edges
    do_reset();
    en = '1;
    do_claim(64'd0);
    chk("t5_notif", 64'(notif), 64'd0);
    set_prio(6, 4);
    pulse_req(32'h40);
    wait_notif("t5_notif_ready");
    do_claim(64'd6);
    do_claim(64'd0);
    chk("t5_no_pulse", 64'(cpl_o), 64'd0);
    id_sb.push_back(64'd0);
    cp_sb.push_back(32'h40);
    claim = 1'b1;
    comp  = 1'b1;
    tick();
    claim = 1'b0;
    comp  = 1'b0;
    chk("t5_both_id", id_o, id_sb.pop_front());
    chk("t5_both_cpl", 64'(cpl_o), 64'(cp_sb.pop_front()));
    tick();
    chk("t5_both_once", 64'(cpl_o), 64'd0);
    do_complete('0);

    // T6: source 0 never pends
    do_reset();
    en = '1;
    set_prio(0, 7);
    pulse_req(32'h1);
    chk("t6_pend", 64'(pend_o), 64'd0);
    watch_quiet(70, "t6_quiet");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
